// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM state encoding,
// default widths and the grant-index width helper.
package bus_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  localparam int DEF_NM  = 2;
  localparam int DEF_AW  = 14;
  localparam int DEF_DW  = 32;
  localparam int DEF_TMO = 255;

  // A single master still needs a 1-bit index so the pointer logic stays uniform.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker. The first requester at or
// after ptr wins, wrapping to the lowest indices when none is found above ptr.
module rr_pick
  import bus_arbiter_pkg::*;
#(
  parameter int NM = DEF_NM,
  parameter int IW = idx_width(DEF_NM)
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] ptr,
  output logic [NM-1:0] gnt,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Descending scans let the lowest qualifying index win; the second scan
  // (indices at or above ptr) overrides any wrapped-around candidate.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = NM - 1; i >= 0; i--) begin
      if (req[i] && (IW'(i) < ptr)) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = IW'(i);
        found  = 1'b1;
      end
    end
    for (int i = NM - 1; i >= 0; i--) begin
      if (req[i] && (IW'(i) >= ptr)) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = IW'(i);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: NM-master round-robin arbiter for stb/ack masters sharing one slave.
// Optional slave-ack timeout with error pulse is built when ARB_TIMEOUT_EN is defined.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter  int NM  = DEF_NM,
  parameter  int AW  = DEF_AW,
  parameter  int DW  = DEF_DW,
  parameter  int TMO = DEF_TMO,
  localparam int SW  = DW / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NM-1:0]    m_stb,
  input  logic [NM-1:0]    m_we,
  input  logic [NM*AW-1:0] m_adr,
  input  logic [NM*SW-1:0] m_sel,
  input  logic [NM*DW-1:0] m_dat_i,
  output logic [DW-1:0]    m_dat_o,
  output logic [NM-1:0]    m_ack,
  output logic [NM-1:0]    m_err,
  output logic [NM-1:0]    gnt,
  output logic             s_stb,
  output logic             s_we,
  output logic [AW-1:0]    s_adr,
  output logic [SW-1:0]    s_sel,
  output logic [DW-1:0]    s_dat_o,
  input  logic [DW-1:0]    s_dat_i,
  input  logic             s_ack
);

  localparam int IW = idx_width(NM);

  if (NM < 1 || NM > 8 || (DW % 8) != 0 || DW < 8 || AW < 1 || TMO < 1) begin : g_bad_param
    $error("bus_arbiter: unsupported parameter combination");
  end

  arb_state_t    state, state_nxt;
  logic [NM-1:0] gnt_nxt;
  logic [IW-1:0] gidx, gidx_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [IW-1:0] ptr_adv;
  logic [NM-1:0] pick_gnt;
  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic          busy;
  logic          done;
  logic          tmo_hit;

  rr_pick #(
    .NM(NM),
    .IW(IW)
  ) u_pick (
    .req  (m_stb),
    .ptr  (ptr),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .found(pick_found)
  );

  assign busy    = (state == ST_BUSY);
  assign done    = busy && s_ack;
  assign ptr_adv = (gidx == IW'(NM - 1)) ? '0 : gidx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      gnt   <= '0;
      gidx  <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      gidx  <= gidx_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // A BUSY slot always ends on slave ack (or timeout), even if the master has
  // withdrawn, so the arbiter can never stall or hold two grants.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    gidx_nxt  = gidx;
    ptr_nxt   = ptr;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_nxt = ST_BUSY;
          gnt_nxt   = pick_gnt;
          gidx_nxt  = pick_idx;
        end else begin
          gnt_nxt = '0;
        end
      end
      ST_BUSY: begin
        if (done || tmo_hit) begin
          state_nxt = ST_IDLE;
          gnt_nxt   = '0;
          ptr_nxt   = ptr_adv;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    s_stb   = busy;
    s_we    = 1'b0;
    s_adr   = '0;
    s_sel   = '0;
    s_dat_o = '0;
    for (int i = 0; i < NM; i++) begin
      if (busy && gnt[i]) begin
        s_we    = m_we[i];
        s_adr   = m_adr[i*AW +: AW];
        s_sel   = m_sel[i*SW +: SW];
        s_dat_o = m_dat_i[i*DW +: DW];
      end
    end
    m_dat_o = busy ? s_dat_i : '0;
    m_ack   = done ? (gnt & m_stb) : '0;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TMO + 1) > 8) ? $clog2(TMO + 1) : 8;

  logic [CW-1:0] cnt;

  // Any IDLE cycle precedes entry to BUSY, so clearing there restarts each slot at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!busy) begin
      cnt <= '0;
    end else if (!s_ack) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tmo_hit = busy && !s_ack && (cnt == CW'(TMO - 1));
  assign m_err   = tmo_hit ? gnt : '0;
`else
  assign tmo_hit = 1'b0;
  assign m_err   = '0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter (NM=2 main instance, NM=3 wrap instance).
// Timeout expectations follow ARB_TIMEOUT_EN in the same way as the design.
module tb_bus_arbiter;

  localparam int NM  = 2;
  localparam int AW  = 14;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NM-1:0]    m_stb, m_we;
  logic [NM*AW-1:0] m_adr;
  logic [NM*SW-1:0] m_sel;
  logic [NM*DW-1:0] m_dat_i;
  logic [DW-1:0]    m_dat_o;
  logic [NM-1:0]    m_ack, m_err, gnt;
  logic             s_stb, s_we, s_ack;
  logic [AW-1:0]    s_adr;
  logic [SW-1:0]    s_sel;
  logic [DW-1:0]    s_dat_o, s_dat_i;

  logic [2:0]       m_stb3, m_we3, m_ack3, m_err3, gnt3;
  logic [3*AW-1:0]  m_adr3;
  logic [3*SW-1:0]  m_sel3;
  logic [3*DW-1:0]  m_dat_i3;
  logic [DW-1:0]    m_dat_o3, s_dat_o3, s_dat_i3;
  logic             s_stb3, s_we3, s_ack3;
  logic [AW-1:0]    s_adr3;
  logic [SW-1:0]    s_sel3;

  typedef struct {
    logic [NM-1:0] ack;
    logic [NM-1:0] err;
    logic [DW-1:0] dat;
  } mexp_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [SW-1:0] sel;
    logic [DW-1:0] dat;
  } sexp_t;

  mexp_t mq[$];
  sexp_t sq[$];

  int n_checks;
  int n_pass;
  int stb_total;
  int cyc;
  int slave_waits;
  logic slave_hang;
  logic slave_fixed;
  logic [DW-1:0] slave_rdata;

  always #5 clk = ~clk;

  bus_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_sel(m_sel), .m_dat_i(m_dat_i),
    .m_dat_o(m_dat_o), .m_ack(m_ack), .m_err(m_err), .gnt(gnt),
    .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack(s_ack)
  );

  assign s_ack3   = s_stb3;
  assign s_dat_i3 = 32'h0BAD_F00D;

  bus_arbiter #(.NM(3), .AW(AW), .DW(DW), .TMO(TMO)) dut3 (
    .clk(clk), .rst(rst),
    .m_stb(m_stb3), .m_we(m_we3), .m_adr(m_adr3), .m_sel(m_sel3), .m_dat_i(m_dat_i3),
    .m_dat_o(m_dat_o3), .m_ack(m_ack3), .m_err(m_err3), .gnt(gnt3),
    .s_stb(s_stb3), .s_we(s_we3), .s_adr(s_adr3), .s_sel(s_sel3), .s_dat_o(s_dat_o3),
    .s_dat_i(s_dat_i3), .s_ack(s_ack3)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic failNote(input string name);
    n_checks++;
    $display("[TB] FAIL %s: event missing or unexpected", name);
  endtask

  task automatic applyStimulus(input int m, input logic we, input logic [AW-1:0] adr,
                               input logic [SW-1:0] sel, input logic [DW-1:0] dat);
    m_we[m]               = we;
    m_adr[m*AW +: AW]     = adr;
    m_sel[m*SW +: SW]     = sel;
    m_dat_i[m*DW +: DW]   = dat;
  endtask

  task automatic expectMaster(input logic [NM-1:0] ack, input logic [NM-1:0] err, input logic [DW-1:0] dat);
    mexp_t e;
    e.ack = ack; e.err = err; e.dat = dat;
    mq.push_back(e);
  endtask

  task automatic expectSlave(input logic we, input logic [AW-1:0] adr, input logic [SW-1:0] sel, input logic [DW-1:0] dat);
    sexp_t e;
    e.we = we; e.adr = adr; e.sel = sel; e.dat = dat;
    sq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #3;
  endtask

  // Waits for any ack/err on the main instance, then steps to the following cycle.
  task automatic waitResp(output logic [NM-1:0] v, output int t);
    v = '0;
    t = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk); #3;
      if (|m_ack || |m_err) begin
        v = m_ack | m_err;
        t = cyc;
        break;
      end
    end
    if (v == '0) failNote("resp_timeout");
    @(posedge clk); #1;
  endtask

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Slave model: acks after slave_waits BUSY cycles; read data is either fixed or address-derived.
  initial begin
    int cnt;
    cnt     = 0;
    s_ack   = 1'b0;
    s_dat_i = '0;
    forever begin
      @(negedge clk);
      if (s_stb) begin
        if (!slave_hang && cnt >= slave_waits) begin
          s_ack   = 1'b1;
          s_dat_i = slave_fixed ? slave_rdata : (32'hA5A5_0000 | 32'(s_adr));
        end else begin
          s_ack   = 1'b0;
          s_dat_i = '0;
        end
        cnt++;
      end else begin
        s_ack = 1'b0;
        cnt   = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes a slave or master transfer.
  initial begin
    sexp_t se;
    mexp_t me;
    stb_total = 0;
    forever begin
      @(negedge clk); #2;
      if (s_stb) stb_total++;
      checkOutput("onehot_inv", {$onehot0(gnt), $onehot0(m_ack), $onehot0(m_err)}, 64'h7);
      if (s_stb && s_ack) begin
        if (sq.size() == 0) failNote("slave_unexpected");
        else begin
          se = sq.pop_front();
          checkOutput("slave_we",  s_we,    se.we);
          checkOutput("slave_adr", s_adr,   se.adr);
          checkOutput("slave_sel", s_sel,   se.sel);
          checkOutput("slave_dat", s_dat_o, se.dat);
        end
      end
      if (|m_ack || |m_err) begin
        if (mq.size() == 0) failNote("master_unexpected");
        else begin
          me = mq.pop_front();
          checkOutput("m_ack", m_ack, me.ack);
          checkOutput("m_err", m_err, me.err);
          if (|me.ack) checkOutput("m_dat_o", m_dat_o, me.dat);
        end
      end
    end
  end

  initial begin
    #200000;
    failNote("global_watchdog");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NM-1:0] v;
    int t, prev, s0;
    n_checks = 0; n_pass = 0;
    rst = 1'b1;
    m_stb = '0; m_we = '0; m_adr = '0; m_sel = '0; m_dat_i = '0;
    m_stb3 = '0; m_we3 = '0; m_adr3 = '0; m_sel3 = '0; m_dat_i3 = '0;
    slave_waits = 0; slave_hang = 1'b0; slave_fixed = 1'b0; slave_rdata = '0;
    prev = 0;

    // Reset must dominate pending requests and zero all slave-side outputs.
    applyStimulus(0, 1'b1, 14'h1234, 4'hF, 32'hCAFE_0000);
    applyStimulus(1, 1'b1, 14'h2345, 4'hF, 32'hCAFE_0001);
    tick();
    m_stb = 2'b11;
    tick();
    sample();
    checkOutput("rst_s_stb",   s_stb,   0);
    checkOutput("rst_gnt",     gnt,     0);
    checkOutput("rst_s_adr",   s_adr,   0);
    checkOutput("rst_s_sel",   s_sel,   0);
    checkOutput("rst_s_we",    s_we,    0);
    checkOutput("rst_s_dat_o", s_dat_o, 0);
    checkOutput("rst_m_dat_o", m_dat_o, 0);
    checkOutput("rst_m_ack",   m_ack,   0);
    checkOutput("rst_gnt3",    gnt3,    0);
    tick();
    m_stb = '0;
    rst   = 1'b0;
    tick();

    // Single master read with two wait states.
    applyStimulus(0, 1'b0, 14'h0010, 4'hF, 32'h0000_AAAA);
    slave_fixed = 1'b1; slave_rdata = 32'hDEAD_BEEF; slave_waits = 2;
    expectSlave(1'b0, 14'h0010, 4'hF, 32'h0000_AAAA);
    expectMaster(2'b01, 2'b00, 32'hDEAD_BEEF);
    s0 = stb_total;
    m_stb = 2'b01;
    waitResp(v, t);
    m_stb = '0;
    checkOutput("single_ack_vec",    v, 2'b01);
    checkOutput("single_stb_cycles", stb_total - s0, 3);
    slave_fixed = 1'b0; slave_waits = 0;

    // Contention from ptr=0: grants alternate 0,1,0,1 two cycles apart.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(0, 1'b0, 14'h0100, 4'hF, 32'h0000_AAAA);
    applyStimulus(1, 1'b0, 14'h0200, 4'hF, 32'h0000_BBBB);
    for (int i = 0; i < 2; i++) begin
      expectSlave(1'b0, 14'h0100, 4'hF, 32'h0000_AAAA);
      expectMaster(2'b01, 2'b00, 32'hA5A5_0100);
      expectSlave(1'b0, 14'h0200, 4'hF, 32'h0000_BBBB);
      expectMaster(2'b10, 2'b00, 32'hA5A5_0200);
    end
    m_stb = 2'b11;
    for (int i = 0; i < 4; i++) begin
      waitResp(v, t);
      checkOutput("contend_order", v, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) checkOutput("contend_gap", t - prev, 2);
      prev = t;
      if (i == 3) m_stb = '0;
    end

    // Master 1 byte write to the top word address.
    applyStimulus(1, 1'b1, 14'h3FFF, 4'b0100, 32'h1122_3344);
    expectSlave(1'b1, 14'h3FFF, 4'b0100, 32'h1122_3344);
    expectMaster(2'b10, 2'b00, 32'hA5A5_3FFF);
    m_stb = 2'b10;
    waitResp(v, t);
    m_stb = '0;
    checkOutput("bytewr_ack_vec", v, 2'b10);

    // Reset while BUSY: grant dropped, no ack, then master 0 wins from ptr=0.
    applyStimulus(1, 1'b0, 14'h0200, 4'hF, 32'h0000_BBBB);
    slave_hang = 1'b1;
    m_stb = 2'b10;
    tick();
    sample();
    checkOutput("pre_rst_s_stb", s_stb, 1);
    checkOutput("pre_rst_gnt",   gnt,   2'b10);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    slave_hang = 1'b0;
    expectSlave(1'b0, 14'h0100, 4'hF, 32'h0000_AAAA);
    expectMaster(2'b01, 2'b00, 32'hA5A5_0100);
    expectSlave(1'b0, 14'h0200, 4'hF, 32'h0000_BBBB);
    expectMaster(2'b10, 2'b00, 32'hA5A5_0200);
    m_stb = 2'b11;
    sample();
    checkOutput("post_rst_s_stb", s_stb, 0);
    checkOutput("post_rst_gnt",   gnt,   0);
    checkOutput("post_rst_err",   m_err, 0);
    waitResp(v, t);
    checkOutput("post_rst_first", v, 2'b01);
    m_stb = 2'b10;
    waitResp(v, t);
    checkOutput("post_rst_second", v, 2'b10);
    m_stb = '0;

    // Master 0 withdraws mid-access: slave completes silently, master 1 follows.
    applyStimulus(0, 1'b0, 14'h0040, 4'hF, 32'h0000_AAAA);
    applyStimulus(1, 1'b0, 14'h0080, 4'hF, 32'h0000_BBBB);
    slave_waits = 3;
    expectSlave(1'b0, 14'h0040, 4'hF, 32'h0000_AAAA);
    expectSlave(1'b0, 14'h0080, 4'hF, 32'h0000_BBBB);
    expectMaster(2'b10, 2'b00, 32'hA5A5_0080);
    m_stb = 2'b01;
    tick();
    tick();
    m_stb = 2'b10;
    waitResp(v, t);
    checkOutput("withdraw_next", v, 2'b10);
    m_stb = '0;
    slave_waits = 0;

`ifdef ARB_TIMEOUT_EN
    // Slave never acks master 0: error after TMO BUSY cycles, then master 1 is served.
    slave_hang = 1'b1;
    expectMaster(2'b00, 2'b01, 32'h0);
    expectSlave(1'b0, 14'h0080, 4'hF, 32'h0000_BBBB);
    expectMaster(2'b10, 2'b00, 32'hA5A5_0080);
    s0 = stb_total;
    m_stb = 2'b11;
    waitResp(v, t);
    checkOutput("tmo_err_vec",    v, 2'b01);
    checkOutput("tmo_stb_cycles", stb_total - s0, TMO);
    slave_hang = 1'b0;
    m_stb = 2'b10;
    waitResp(v, t);
    checkOutput("tmo_next", v, 2'b10);
    m_stb = '0;
`else
    // Without the timeout a silent slave holds the bus indefinitely.
    slave_hang = 1'b1;
    m_stb = 2'b01;
    repeat (12) tick();
    sample();
    checkOutput("hang_s_stb", s_stb, 1);
    checkOutput("hang_m_err", m_err, 0);
    checkOutput("hang_gnt",   gnt,   2'b01);
    tick();
    rst = 1'b1;
    m_stb = '0;
    tick();
    rst = 1'b0;
    slave_hang = 1'b0;
`endif

    // NM=3 wrap: master 2 served, then {0,2} requesting picks 0, then 2 again.
    tick();
    m_stb3 = 3'b100;
    tick();
    sample();
    checkOutput("wrap_gnt_a", gnt3,   3'b100);
    checkOutput("wrap_ack_a", m_ack3, 3'b100);
    tick();
    m_stb3 = 3'b101;
    tick();
    sample();
    checkOutput("wrap_gnt_b", gnt3,   3'b001);
    checkOutput("wrap_ack_b", m_ack3, 3'b001);
    tick();
    tick();
    sample();
    checkOutput("wrap_gnt_c", gnt3,   3'b100);
    checkOutput("wrap_err",   m_err3, 3'b000);
    tick();
    m_stb3 = '0;

    repeat (4) tick();
    checkOutput("mq_drained", mq.size(), 0);
    checkOutput("sq_drained", sq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- N-master round-robin arbiter. Lets several stb/ack bus masters (CPU instruction port, CPU data port, later DMA) share one single-port memory or slave.
- Generalises the two-port, fixed-width CPU-to-memory hookup to NM masters with parametrised address and data width.
- Sits between the CPU bus ports and the memory. Serialises accesses and routes ack and read data back to the granted master only.

Parameters:
- NM, 2, number of masters (1..8); master 0 is lowest index for tie-break at reset.
- AW, 14, word-address width.
- DW, 32, data width; must be a multiple of 8; select width SW = DW/8.
- TMO, 255, slave-ack timeout in cycles (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- m_stb  in  NM  per-master request strobe; held high until ack/err.
- m_we  in  NM  per-master write enable.
- m_adr  in  NM*AW  flattened addresses; master i at [i*AW +: AW].
- m_sel  in  NM*SW  flattened byte selects.
- m_dat_i  in  NM*DW  flattened write data.
- m_dat_o  out  DW  read data; shared by all masters, valid only with that master's ack.
- m_ack  out  NM  one-hot ack pulse.
- m_err  out  NM  one-hot error pulse; constant 0 without ARB_TIMEOUT_EN.
- gnt  out  NM  registered one-hot current grant; for debug and coverage.
- s_stb  out  1  slave strobe.
- s_we  out  1  slave write enable.
- s_adr  out  AW  slave address.
- s_sel  out  SW  slave byte selects.
- s_dat_o  out  DW  slave write data.
- s_dat_i  in  DW  slave read data.
- s_ack  in  1  slave ack.

Behaviour:
- FSM states: IDLE, BUSY.
- Reset, synchronous and active-high:
  - state=IDLE, gnt=0, round-robin pointer ptr=0.
  - Counter cleared.
  - s_stb=0, m_ack=0, m_err=0.
  - m_dat_o=0, s_adr=0, s_sel=0, s_we=0, s_dat_o=0.
- IDLE:
  - If any m_stb is high, select the first requester searching ptr, ptr+1, ... NM-1, 0, ... (wrap modulo NM).
  - Register gnt one-hot and go to BUSY.
  - If no requester, stay in IDLE with gnt=0.
- BUSY:
  - s_stb=1. s_we, s_adr, s_sel, s_dat_o are muxed combinationally from the granted master.
  - s_stb, m_ack and m_err are forced 0 outside BUSY.
- Completion:
  - In BUSY with s_ack=1: m_ack[g]=1 combinationally in the same cycle, and m_dat_o=s_dat_i.
  - Next edge: state=IDLE, gnt=0, ptr=(g+1) mod NM.
  - The master must drop or replace its stb in the cycle after ack.
- Latency:
  - Request seen at cycle t gives s_stb at t+1. A zero-wait slave acks at t+1.
  - Back-to-back accesses therefore take 2 cycles each. The next arbitration happens in the IDLE cycle after completion.
- Fairness: with all NM masters requesting continuously, each is served once every NM transactions.
- Request withdrawal:
  - A master dropping stb while granted in BUSY is a protocol violation.
  - The arbiter holds the grant anyway and completes the slave transaction, without a master ack.
  - It must not hang or grant two masters.
- Simultaneous events: a new request arriving in the same cycle as s_ack is not granted until the following IDLE cycle.
- Reset mid-transaction:
  - Grant is dropped and s_stb=0 from the next cycle.
  - No ack or err is generated.
  - ptr returns to 0.
- Masking: s_ack while in IDLE is ignored and produces no m_ack.
- Grant invariant: at most one bit of gnt, m_ack or m_err is set at any time.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to BUSY and increments each BUSY cycle without s_ack.
  - On reaching TMO: m_err[g] pulses for 1 cycle, s_stb drops, state goes to IDLE, ptr advances as on completion.
  - s_ack in the same cycle as the timeout wins: ack is issued, no err.
- Undefined: no counter is built, m_err is tied to 0, and BUSY waits indefinitely.

Decomposition:
- Shared package/header: state encodings (ST_IDLE, ST_BUSY) and default widths.
- One sub-module, rr_pick: combinational round-robin priority picker. Inputs req[NM] and ptr; outputs one-hot grant and its index.
- Instantiated once; all muxing and the FSM stay in bus_arbiter.

Test Plan:
- Single master: NM=2, master0 reads adr 0x0010, slave acks after 2 waits returning 0xDEADBEEF -> s_stb high 3 cycles, m_ack[0] one cycle with m_dat_o=0xDEADBEEF, m_ack[1]=0.
- Contention: both masters request continuously, zero-wait slave -> grants alternate 0,1,0,1; each ack 2 cycles apart; never two gnt bits set.
- Byte write: master1 writes 0x11223344 with sel=4'b0100 to adr 0x3FFF -> slave sees we=1, sel=0100, adr 0x3FFF, data 0x11223344.
- Reset mid-transaction: rst asserted in BUSY before s_ack -> next cycle s_stb=0, gnt=0, no ack or err; after release, master0 is served first.
- Timeout (ARB_TIMEOUT_EN, TMO=4): slave never acks -> m_err[g] pulses after 4 BUSY cycles, then the other pending master is granted. With the macro undefined -> s_stb stays high and m_err stays 0.
- NM=3 wrap: master2 served, then masters 0 and 2 both request -> master0 granted next.
